// File: rtl/id_stage.sv
// Decode/operand-fetch stage: 32-entry register file plus a one-deep valid/ready operand register.
// Optional macro ID_STAGE_BYPASS_EN forwards same-cycle writeback data into captured operands.
module id_stage #(
   parameter int unsigned n_bits = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [15:0]       imm,
   input  logic              alu_src,
   input  logic [2:0]        alu_ctrl_in,
   input  logic              we,
   input  logic [4:0]        wa,
   input  logic [n_bits-1:0] wd,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [n_bits-1:0] srca,
   output logic [n_bits-1:0] srcb,
   output logic [2:0]        ALUControl,
   output logic [n_bits-1:0] rt_data
);

   logic [n_bits-1:0] rf_q [32];

   logic              out_valid_q, out_valid_d;
   logic [n_bits-1:0] srca_q, srca_d;
   logic [n_bits-1:0] srcb_q, srcb_d;
   logic [n_bits-1:0] rt_data_q, rt_data_d;
   logic [2:0]        alu_ctrl_q, alu_ctrl_d;

   logic              accept;
   logic              wr_en;
   logic [n_bits-1:0] rd_a, rd_b, imm_ext;

   assign wr_en    = we && (wa != 5'd0);
   assign in_ready = !out_valid_q || out_ready;
   // Flush has priority over a same-cycle accept.
   assign accept   = in_valid && in_ready && !flush;
   assign imm_ext  = {{(n_bits - 16){imm[15]}}, imm};

   always_comb begin
      rd_a = rf_q[rs];
      rd_b = rf_q[rt];
`ifdef ID_STAGE_BYPASS_EN
      if (wr_en && (wa == rs)) rd_a = wd;
      if (wr_en && (wa == rt)) rd_b = wd;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (wr_en) begin
         rf_q[wa] <= wd;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      srca_d      = srca_q;
      srcb_d      = srcb_q;
      rt_data_d   = rt_data_q;
      alu_ctrl_d  = alu_ctrl_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         srca_d      = rd_a;
         srcb_d      = alu_src ? imm_ext : rd_b;
         rt_data_d   = rd_b;
         alu_ctrl_d  = alu_ctrl_in;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         srca_q      <= '0;
         srcb_q      <= '0;
         rt_data_q   <= '0;
         alu_ctrl_q  <= 3'b000;
      end else begin
         out_valid_q <= out_valid_d;
         srca_q      <= srca_d;
         srcb_q      <= srcb_d;
         rt_data_q   <= rt_data_d;
         alu_ctrl_q  <= alu_ctrl_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign srca       = srca_q;
   assign srcb       = srcb_q;
   assign rt_data    = rt_data_q;
   assign ALUControl = alu_ctrl_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage; expected values are hand-computed constants.
module tb_id_stage;

   localparam int unsigned NBits = 32;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       rs, rt;
   logic [15:0]      imm;
   logic             alu_src;
   logic [2:0]       alu_ctrl_in;
   logic             we;
   logic [4:0]       wa;
   logic [NBits-1:0] wd;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [NBits-1:0] srca, srcb, rt_data;
   logic [2:0]       ALUControl;

   int checks;
   int failures;

   id_stage #(.n_bits(NBits)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .rs         (rs),
      .rt         (rt),
      .imm        (imm),
      .alu_src    (alu_src),
      .alu_ctrl_in(alu_ctrl_in),
      .we         (we),
      .wa         (wa),
      .wd         (wd),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .srca       (srca),
      .srcb       (srcb),
      .ALUControl (ALUControl),
      .rt_data    (rt_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      rs          = '0;
      rt          = '0;
      imm         = '0;
      alu_src     = 1'b0;
      alu_ctrl_in = 3'b000;
      we          = 1'b0;
      wa          = '0;
      wd          = '0;
      flush       = 1'b0;
      out_ready   = 1'b1;

      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_srca", srca, 0);
      check("rst_alu_ctrl", ALUControl, 0);
      check("rst_in_ready", in_ready, 1);
      #10 rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", in_ready, 1);

      // Load R5 = 0xA, R6 = 0x3.
      we = 1'b1; wa = 5'd5; wd = 32'h0000_000A;
      tick();
      wa = 5'd6; wd = 32'h0000_0003;
      tick();
      we = 1'b0;

      // Register-register accept.
      in_valid = 1'b1; rs = 5'd5; rt = 5'd6; alu_src = 1'b0; alu_ctrl_in = 3'b010;
      tick();
      check("rr_out_valid", out_valid, 1);
      check("rr_srca", srca, 32'h0000_000A);
      check("rr_srcb", srcb, 32'h0000_0003);
      check("rr_alu_ctrl", ALUControl, 3'b010);
      check("rr_rt_data", rt_data, 32'h0000_0003);

      // Immediate operand, negative then positive.
      alu_src = 1'b1; imm = 16'hFFFC;
      tick();
      check("imm_neg_srcb", srcb, 32'hFFFF_FFFC);
      check("imm_neg_rt_data", rt_data, 32'h0000_0003);
      imm = 16'h7FFF;
      tick();
      check("imm_pos_srcb", srcb, 32'h0000_7FFF);

      // Writes to R0 are ignored; drain with no new accept.
      in_valid = 1'b0; alu_src = 1'b0;
      we = 1'b1; wa = 5'd0; wd = 32'hDEAD_BEEF;
      tick();
      check("drain_out_valid", out_valid, 0);
      we = 1'b0;
      in_valid = 1'b1; rs = 5'd0; rt = 5'd5; alu_ctrl_in = 3'b001;
      tick();
      check("r0_srca", srca, 0);
      check("r0_srcb", srcb, 32'h0000_000A);

      // Stall for three cycles with a pending instruction.
      out_ready = 1'b0; rs = 5'd6; rt = 5'd5; alu_ctrl_in = 3'b111;
      #1;
      check("stall_in_ready", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_out_valid", out_valid, 1);
         check("stall_srca", srca, 0);
         check("stall_alu_ctrl", ALUControl, 3'b001);
      end
      out_ready = 1'b1;
      #1;
      check("unstall_in_ready", in_ready, 1);
      tick();
      check("unstall_srca", srca, 32'h0000_0003);
      check("unstall_srcb", srcb, 32'h0000_000A);
      check("unstall_alu_ctrl", ALUControl, 3'b111);

      // Same-cycle write/read collision on R7 (old value 0x22).
      in_valid = 1'b0;
      we = 1'b1; wa = 5'd7; wd = 32'h0000_0022;
      tick();
      wd = 32'h0000_0011;
      in_valid = 1'b1; rs = 5'd7; rt = 5'd0; alu_ctrl_in = 3'b011;
      tick();
`ifdef ID_STAGE_BYPASS_EN
      check("collide_srca", srca, 32'h0000_0011);
`else
      check("collide_srca", srca, 32'h0000_0022);
`endif
      we = 1'b0;
      tick();
      check("r7_after_write", srca, 32'h0000_0011);

      // Flush while stalled, with a writeback to R8 in the same cycle.
      out_ready = 1'b0; flush = 1'b1;
      we = 1'b1; wa = 5'd8; wd = 32'h0000_0055;
      tick();
      check("flush_out_valid", out_valid, 0);
      we = 1'b0;
      // Flush must also block an accept that in_ready would allow.
      #1;
      check("flush_in_ready", in_ready, 1);
      tick();
      check("flush_block_accept", out_valid, 0);
      flush = 1'b0; out_ready = 1'b1; rs = 5'd8;
      tick();
      check("flush_wb_r8", srca, 32'h0000_0055);

      // Asynchronous reset mid-stall.
      out_ready = 1'b0; rs = 5'd5; alu_ctrl_in = 3'b110;
      tick();
      check("pre_rst_out_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_out_valid", out_valid, 0);
      check("async_srca", srca, 0);
      check("async_srcb", srcb, 0);
      check("async_rt_data", rt_data, 0);
      check("async_alu_ctrl", ALUControl, 0);
      check("async_in_ready", in_ready, 1);
      #2 rst_n = 1'b1;
      out_ready = 1'b1; rs = 5'd5; rt = 5'd6; alu_ctrl_in = 3'b100;
      tick();
      check("post_rst_accept", out_valid, 1);
      check("post_rst_rf_cleared", srca, 0);
      check("post_rst_alu_ctrl", ALUControl, 3'b100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
